// File: rtl/usb_pkt_rx.sv
// usb_pkt_rx: serial-to-packet receiver. Hunts SYNC in the qualified bit
// stream, validates the PID, collects token/data/handshake bodies, checks
// CRC5/CRC16 and presents decoded fields with one-cycle result pulses.
// Optional build macro: USB_RX_ADDR_FILTER_EN (drop tokens not addressed to
// 7'b1010000 without any pulse).
module usb_pkt_rx #(
  parameter int unsigned TIMEOUT_LEN = 255,
  parameter logic [7:0]  SYNC_PAT    = 8'b00000001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_bit,
  input  logic        rx_valid,
  output logic        pkt_valid,
  output logic [1:0]  pkt_type,
  output logic [7:0]  pid,
  output logic [6:0]  addr,
  output logic [3:0]  endp,
  output logic [63:0] data,
  output logic        crc_err,
  output logic        pid_err,
  output logic        timeout_err,
  output logic        busy
);

  localparam int unsigned SW = $clog2(TIMEOUT_LEN + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT_LEN - 1);

  localparam logic [7:0] PID_OUT  = 8'b10000111;
  localparam logic [7:0] PID_IN   = 8'b10010110;
  localparam logic [7:0] PID_DATA = 8'b11000011;
  localparam logic [7:0] PID_ACK  = 8'b01001011;
  localparam logic [7:0] PID_NAK  = 8'b01011010;

  typedef enum logic [2:0] {HUNT, PID, TOK, DAT, EMIT} state_t;

  state_t          state, state_next;
  logic [6:0]      hunt_sh;   // last 7 valid bits; the incoming bit completes the window
  logic [7:0]      pid_sh;
  logic [10:0]     tok_sh;
  logic [63:0]     dat_sh;
  logic [14:0]     crc_sh;    // received CRC field, newest bit arrives on rx_bit
  logic [4:0]      crc5;
  logic [15:0]     crc16;
  logic [6:0]      bit_cnt;
  logic [SW-1:0]   stall_cnt;

  logic [7:0]  pid_full;
  logic        pid_ok, in_pkt, addr_pass;
  logic        crc5_fb, crc16_fb;
  logic [4:0]  crc5_next;
  logic [15:0] crc16_next;
  logic        tok_crc_ok, dat_crc_ok;
  logic        emit, set_crc_err, set_pid_err, set_timeout;
  logic [1:0]  emit_type;

  assign busy     = (state != HUNT);
  assign in_pkt   = (state == PID) || (state == TOK) || (state == DAT);
  assign pid_full = {pid_sh[6:0], rx_bit};
  assign pid_ok   = (pid_full[7:4] == ~pid_full[3:0]) &&
                    ((pid_full == PID_OUT) || (pid_full == PID_IN) || (pid_full == PID_DATA) ||
                     (pid_full == PID_ACK) || (pid_full == PID_NAK));

  assign crc5_fb    = crc5[4] ^ rx_bit;
  assign crc5_next  = {crc5[3], crc5[2], crc5[1] ^ crc5_fb, crc5[0], crc5_fb};
  assign crc16_fb   = crc16[15] ^ rx_bit;
  assign crc16_next = {crc16[14] ^ crc16_fb, crc16[13:2], crc16[1] ^ crc16_fb, crc16[0], crc16_fb};

  assign tok_crc_ok = ({crc_sh[3:0], rx_bit} == ~crc5);
  assign dat_crc_ok = ({crc_sh[14:0], rx_bit} == ~crc16);

`ifdef USB_RX_ADDR_FILTER_EN
  assign addr_pass = (tok_sh[10:4] == 7'b1010000);
`else
  assign addr_pass = 1'b1;
`endif

  // Next-state and result-pulse decisions
  always_comb begin
    state_next  = state;
    emit        = 1'b0;
    emit_type   = 2'b00;
    set_crc_err = 1'b0;
    set_pid_err = 1'b0;
    set_timeout = 1'b0;
    if (in_pkt && !rx_valid && (stall_cnt == STALL_LAST)) begin
      set_timeout = 1'b1;
      state_next  = HUNT;
    end else begin
      case (state)
        HUNT: if (rx_valid && ({hunt_sh, rx_bit} == SYNC_PAT)) state_next = PID;
        PID: if (rx_valid && (bit_cnt == 7'd7)) begin
          if (!pid_ok) begin
            set_pid_err = 1'b1;
            state_next  = HUNT;
          end else if ((pid_full == PID_OUT) || (pid_full == PID_IN)) begin
            state_next = TOK;
          end else if (pid_full == PID_DATA) begin
            state_next = DAT;
          end else begin
            emit       = 1'b1;
            emit_type  = 2'b11;
            state_next = EMIT;
          end
        end
        TOK: if (rx_valid && (bit_cnt == 7'd15)) begin
          if (tok_crc_ok) begin
            // filtered tokens still spend the EMIT cycle, just without output
            emit       = addr_pass;
            emit_type  = 2'b01;
            state_next = EMIT;
          end else begin
            set_crc_err = 1'b1;
            state_next  = HUNT;
          end
        end
        DAT: if (rx_valid && (bit_cnt == 7'd79)) begin
          if (dat_crc_ok) begin
            emit       = 1'b1;
            emit_type  = 2'b10;
            state_next = EMIT;
          end else begin
            set_crc_err = 1'b1;
            state_next  = HUNT;
          end
        end
        EMIT: state_next = HUNT;
        default: state_next = HUNT;
      endcase
    end
  end

  // State register, shift/CRC datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      hunt_sh     <= '1;
      pid_sh      <= '0;
      tok_sh      <= '0;
      dat_sh      <= '0;
      crc_sh      <= '0;
      crc5        <= '1;
      crc16       <= '1;
      bit_cnt     <= '0;
      stall_cnt   <= '0;
      pkt_valid   <= 1'b0;
      pkt_type    <= '0;
      pid         <= '0;
      addr        <= '0;
      endp        <= '0;
      data        <= '0;
      crc_err     <= 1'b0;
      pid_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      pkt_valid   <= emit;
      crc_err     <= set_crc_err;
      pid_err     <= set_pid_err;
      timeout_err <= set_timeout;

      if (rx_valid && ((state == HUNT) || (state == EMIT))) hunt_sh <= {hunt_sh[5:0], rx_bit};

      if (state_next != state)        bit_cnt <= '0;
      else if (rx_valid && in_pkt)    bit_cnt <= bit_cnt + 7'd1;

      if (!in_pkt || (state_next != state) || rx_valid) stall_cnt <= '0;
      else                                              stall_cnt <= stall_cnt + 1'b1;

      if (state == PID) begin
        crc5  <= '1;
        crc16 <= '1;
        if (rx_valid) pid_sh <= pid_full;
      end
      if ((state == TOK) && rx_valid) begin
        if (bit_cnt < 7'd11) begin
          tok_sh <= {tok_sh[9:0], rx_bit};
          crc5   <= crc5_next;
        end else begin
          crc_sh <= {crc_sh[13:0], rx_bit};
        end
      end
      if ((state == DAT) && rx_valid) begin
        if (bit_cnt < 7'd64) begin
          dat_sh <= {dat_sh[62:0], rx_bit};
          crc16  <= crc16_next;
        end else begin
          crc_sh <= {crc_sh[13:0], rx_bit};
        end
      end

      if (emit) begin
        pkt_type <= emit_type;
        if (state == PID) begin
          pid <= pid_full;
        end else if (state == TOK) begin
          pid  <= pid_sh;
          addr <= tok_sh[10:4];
          endp <= tok_sh[3:0];
        end else begin
          pid  <= pid_sh;
          data <= dat_sh;
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_pkt_rx.sv
// Scoreboard bench for usb_pkt_rx: the driver pushes the expected result of
// each packet (with the time it must appear) into a queue; a monitor on the
// falling edge pops and compares whenever a result is due or a pulse appears.
module tb_usb_pkt_rx;

  logic        clk, rst, rx_bit, rx_valid;
  logic        pkt_valid, crc_err, pid_err, timeout_err, busy;
  logic [1:0]  pkt_type;
  logic [7:0]  pid;
  logic [6:0]  addr;
  logic [3:0]  endp;
  logic [63:0] data;

  usb_pkt_rx #(.TIMEOUT_LEN(255), .SYNC_PAT(8'b00000001)) dut (
    .clk(clk), .rst(rst), .rx_bit(rx_bit), .rx_valid(rx_valid),
    .pkt_valid(pkt_valid), .pkt_type(pkt_type), .pid(pid), .addr(addr),
    .endp(endp), .data(data), .crc_err(crc_err), .pid_err(pid_err),
    .timeout_err(timeout_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ev;   // {pkt_valid, crc_err, pid_err, timeout_err}
    logic [1:0]  typ;
    logic [7:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
    time         t;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  bit   mon_en = 1'b0;
  time  t_edge;
  logic [7:0]  sync_v = 8'b00000001;

  // reference model: fields currently held at the outputs
  logic [7:0]  m_pid;
  logic [6:0]  m_addr;
  logic [3:0]  m_endp;
  logic [63:0] m_data;

`ifdef USB_RX_ADDR_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // 0 invalid, 1 token, 2 data, 3 handshake
  function automatic int classify(input logic [7:0] p);
    if (p[7:4] != ~p[3:0]) return 0;
    case (p)
      8'h87, 8'h96: return 1;
      8'hC3:        return 2;
      8'h4B, 8'h5A: return 3;
      default:      return 0;
    endcase
  endfunction

  // CRC5 as polynomial division by x^5+x^2+1, inverted result
  function automatic logic [4:0] crc5_of(input logic [10:0] m);
    logic [4:0] r = '1;
    for (int i = 10; i >= 0; i--) begin
      bit fb = r[4] ^ m[i];
      r = {r[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    return ~r;
  endfunction

  // CRC16 as polynomial division by x^16+x^15+x^2+1, inverted result
  function automatic logic [15:0] crc16_of(input logic [63:0] m);
    logic [15:0] r = '1;
    for (int i = 63; i >= 0; i--) begin
      bit fb = r[15] ^ m[i];
      r = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return ~r;
  endfunction

  task automatic push(input logic [3:0] ev, input logic [1:0] typ);
    exp_t e;
    e.ev = ev; e.typ = typ; e.pid = m_pid; e.addr = m_addr;
    e.endp = m_endp; e.data = m_data; e.t = t_edge + 5;
    sb.push_back(e);
  endtask

  // mode 0: continuous, 1: one idle cycle before each bit, 2: random idle cycles
  task automatic send_bit(input logic b, input int mode);
    int gaps = 0;
    if (mode == 1) gaps = 1;
    else if (mode == 2 && $urandom_range(0, 2) == 0) gaps = $urandom_range(1, 2);
    for (int g = 0; g < gaps; g++) begin
      rx_valid = 1'b0; rx_bit = 1'($urandom);
      @(posedge clk); #1;
    end
    rx_valid = 1'b1; rx_bit = b;
    @(posedge clk); t_edge = $time; #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_head(input logic [7:0] p, input int mode);
    for (int i = 0; i < 3; i++) send_bit(1'b1, mode);
    for (int i = 7; i >= 0; i--) send_bit(sync_v[i], mode);
    chk("busy_after_sync", 64'(busy), 64'd1);
    for (int i = 7; i >= 0; i--) send_bit(p[i], mode);
  endtask

  // crc_in is XORed into the golden CRC when crc_auto is set, else sent as-is
  task automatic send_pkt(input logic [7:0] p, input logic [6:0] a, input logic [3:0] e,
                          input logic [63:0] d, input bit crc_auto, input logic [15:0] crc_in,
                          input int mode, input int stall_at, input int stall_len);
    int cls = classify(p);
    bit body[$];
    logic [15:0] fld;
    bit good;
    send_head(p, mode);
    if (cls == 0) begin push(4'b0010, 2'b00); return; end
    if (cls == 3) begin m_pid = p; push(4'b1000, 2'b11); return; end
    if (cls == 1) begin
      fld  = (crc_auto ? {11'd0, crc5_of({a, e})} : 16'd0) ^ crc_in;
      good = (fld[4:0] == crc5_of({a, e}));
      for (int i = 6; i >= 0; i--) body.push_back(a[i]);
      for (int i = 3; i >= 0; i--) body.push_back(e[i]);
      for (int i = 4; i >= 0; i--) body.push_back(fld[i]);
    end else begin
      fld  = (crc_auto ? crc16_of(d) : 16'd0) ^ crc_in;
      good = (fld == crc16_of(d));
      for (int i = 63; i >= 0; i--) body.push_back(d[i]);
      for (int i = 15; i >= 0; i--) body.push_back(fld[i]);
    end
    for (int i = 0; i < body.size(); i++) begin
      if (i == stall_at) begin
        for (int s = 1; s <= stall_len; s++) begin
          rx_valid = 1'b0; rx_bit = 1'($urandom);
          @(posedge clk); t_edge = $time; #1;
          if (s == 255) begin push(4'b0001, 2'b00); return; end
        end
      end
      send_bit(body[i], mode);
    end
    if (!good) push(4'b0100, 2'b00);
    else if (cls == 1) begin
      if (!(FILTER && a != 7'h50)) begin
        m_pid = p; m_addr = a; m_endp = e;
        push(4'b1000, 2'b01);
      end
    end else begin
      m_pid = p; m_data = d;
      push(4'b1000, 2'b10);
    end
  endtask

  // monitor: compare against the due scoreboard entry, flag stray pulses
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [3:0] act;
    if (mon_en) begin
      act = {pkt_valid, crc_err, pid_err, timeout_err};
      if (sb.size() > 0 && sb[0].t == $time) begin
        e = sb.pop_front();
        chk("events", 64'(act), 64'(e.ev));
        chk("busy", 64'(busy), 64'(e.ev[3]));
        if (e.ev[3]) begin
          chk("pkt_type", 64'(pkt_type), 64'(e.typ));
          chk("pid", 64'(pid), 64'(e.pid));
          chk("addr", 64'(addr), 64'(e.addr));
          chk("endp", 64'(endp), 64'(e.endp));
          chk("data", data, e.data);
        end
      end else if (act != 4'b0000) begin
        checks++;
        fails++;
        $display("FAIL unexpected_event: got %b expected 0000 at %0t", act, $time);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] d0, d1;
    logic [7:0]  p;
    logic [15:0] xm;
    int k;
    rst = 1'b1; rx_bit = 1'b0; rx_valid = 1'b0;
    m_pid = '0; m_addr = '0; m_endp = '0; m_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pkt_valid", 64'(pkt_valid), 64'd0);
    chk("rst_errs", 64'({crc_err, pid_err, timeout_err}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fields", 64'({pkt_type, pid, addr, endp}), 64'd0);
    chk("rst_data", data, 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // directed token, good and with last CRC bit flipped
    send_pkt(8'h87, 7'b1010000, 4'b0010, 64'd0, 1'b0, 16'b00001, 0, -1, 0);
    send_pkt(8'h87, 7'b1010000, 4'b0010, 64'd0, 1'b0, 16'b00000, 0, -1, 0);
    // handshake then bad PID
    send_pkt(8'h4B, 7'd0, 4'd0, 64'd0, 1'b1, 16'd0, 0, -1, 0);
    send_pkt(8'h4A, 7'd0, 4'd0, 64'd0, 1'b1, 16'd0, 0, -1, 0);
    // data with toggling valid; then bit 0 corrupted against original CRC
    d0 = 64'h0123456789abcdef;
    d1 = d0 ^ 64'd1;
    send_pkt(8'hC3, 7'd0, 4'd0, d0, 1'b1, 16'd0, 1, -1, 0);
    send_pkt(8'hC3, 7'd0, 4'd0, d1, 1'b0, crc16_of(d0), 1, -1, 0);
    // stall after 5 address bits: 255 cycles times out, 254 does not
    send_pkt(8'h96, 7'h50, 4'h3, 64'd0, 1'b1, 16'd0, 0, 5, 255);
    send_pkt(8'h96, 7'h51, 4'h4, 64'd0, 1'b1, 16'd0, 0, 5, 254);
    // reset mid-data, then a handshake
    send_head(8'hC3, 0);
    for (int i = 0; i < 30; i++) send_bit(1'($urandom), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_pid = '0; m_addr = '0; m_endp = '0; m_data = '0;
    chk("busy_after_rst", 64'(busy), 64'd0);
    send_pkt(8'h5A, 7'd0, 4'd0, 64'd0, 1'b1, 16'd0, 0, -1, 0);
    // token to a foreign address (dropped only when filtering is built in)
    send_pkt(8'h87, 7'h01, 4'h7, 64'd0, 1'b1, 16'd0, 0, -1, 0);

    // randomized packets
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 5);
      case (k)
        0: p = 8'h87;
        1: p = 8'h96;
        2: p = 8'hC3;
        3: p = 8'h4B;
        4: p = 8'h5A;
        default: p = 8'($urandom_range(0, 255));
      endcase
      xm = 16'd0;
      if ($urandom_range(0, 3) == 0)
        xm = 16'd1 << $urandom_range(0, (classify(p) == 1) ? 4 : 15);
      send_pkt(p, ($urandom_range(0, 3) == 0) ? 7'h50 : 7'($urandom), 4'($urandom),
               {$urandom, $urandom}, 1'b1, xm, $urandom_range(0, 2), -1, 0);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/usb_pkt_rx.md
Name: usb_pkt_rx

Overview:
- Serial-to-packet receiver for the USB-style link. It is the receive-side counterpart of the packet-to-serial transmit path with CRC generation.
- Hunts SYNC in a qualified serial bit stream, captures and validates the PID, and collects the token, data or handshake body.
- Checks CRC5 on tokens and CRC16 on data packets, then presents decoded fields with a one-cycle valid pulse to the protocol FSM.

Parameters:
- TIMEOUT_LEN, 255: maximum consecutive cycles with rx_valid low inside a packet before abort.
- SYNC_PAT, 8'b00000001: SYNC pattern, oldest bit in the MSB.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rx_bit  in  1  serial data bit, MSB-first per field.
- rx_valid  in  1  rx_bit is sampled only in cycles where this is high.
- pkt_valid  out  1  one-cycle pulse; decoded fields are valid.
- pkt_type  out  2  01 token, 10 data, 11 handshake.
- pid  out  8  received PID byte.
- addr  out  7  token address.
- endp  out  4  token endpoint.
- data  out  64  data payload; first-received bit is data[63].
- crc_err  out  1  one-cycle pulse; CRC mismatch, packet dropped.
- pid_err  out  1  one-cycle pulse; bad or unknown PID, packet dropped.
- timeout_err  out  1  one-cycle pulse; mid-packet stall exceeded TIMEOUT_LEN.
- busy  out  1  high in any state other than HUNT.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. Reset has priority over everything, including mid-packet; any partial packet is discarded.
- Reset values: state=HUNT; all outputs 0, including fields, pulses and busy.
- States: HUNT, PID, TOK, DAT, EMIT.
- HUNT:
  - 8-bit sliding shift register of valid bits.
  - When the register equals SYNC_PAT on a valid bit, go to PID and clear the bit counter.
  - Overlapping matches are allowed.
- PID:
  - Shift 8 valid bits.
  - On the 8th bit, check pid[7:4] == ~pid[3:0] and membership in the defined set: 8'b10000111 OUT, 8'b10010110 IN, 8'b11000011 DATA, 8'b01001011 ACK, 8'b01011010 NAK.
  - On failure: pulse pid_err and return to HUNT.
  - OUT or IN goes to TOK. DATA goes to DAT. ACK or NAK goes to EMIT with pkt_type=11.
- TOK:
  - 16 valid bits: addr (7), endp (4), crc5 (5).
  - The CRC5 LFSR is initialised to 5'h1f at PID exit. Update per bit: n0=q4^b, n1=q0, n2=q1^q4^b, n3=q2, n4=q3. The LFSR runs over the 11 addr/endp bits only.
  - Pass if the received crc5 field (first bit in [4]) equals ~LFSR.
  - Pass goes to EMIT. Fail pulses crc_err and returns to HUNT.
- DAT:
  - 80 valid bits: 64 data, then crc16.
  - The CRC16 LFSR is initialised to 16'hffff. Taps: n0=b^q15, n2=q1^q15^b, n15=q14^q15^b, all other bits shift.
  - The LFSR runs over the 64 data bits. Pass if the received crc16 field equals ~LFSR; fail pulses crc_err.
- EMIT:
  - Drive pkt_valid=1 for exactly one cycle, then go to HUNT.
  - Latency: pkt_valid is high in the cycle after the clock edge that sampled the last bit.
  - Bits arriving during EMIT are fed to the HUNT shift register.
- Field holding: pid, addr, endp and data hold their values until the next pkt_valid. Fields not carried by a packet type retain their old values; only pkt_type distinguishes which fields are new.
- Timeout:
  - In PID, TOK or DAT, a counter increments on each cycle with rx_valid low and clears on rx_valid high.
  - When it reaches TIMEOUT_LEN, pulse timeout_err and go to HUNT.
  - In HUNT the counter is held at 0.
- Error precedence: only one error pulse per packet. Errors and pkt_valid are never asserted together.
- Bit counter width is 7 bits; it never wraps within a packet (max 80).

Optional Feature:
- Macro: USB_RX_ADDR_FILTER_EN.
- Defined: a token whose addr != 7'b1010000, even with a good CRC, is dropped silently. No pkt_valid and no error pulse; the block returns to HUNT at the cycle EMIT would have occupied.
- Undefined: all CRC-valid tokens are emitted regardless of address.

Test Plan:
- SYNC, then OUT 8'b10000111, addr 1010000, endp 0010, crc5 00001, with rx_valid continuous -> one pkt_valid, pkt_type=01, pid=8'h87, addr=7'h50, endp=4'h2, no error pulses.
- Same token with the last crc bit flipped (00000) -> crc_err pulse, no pkt_valid, busy low on the next cycle.
- SYNC, then ACK 8'b01001011 -> pkt_valid one cycle after the PID's last bit, pkt_type=11, pid=8'h4b. Then SYNC, then PID 8'b01001010 -> pid_err.
- SYNC, DATA PID, data=64'h0123456789abcdef, golden-model CRC16, with rx_valid toggling 1/0 each cycle -> pkt_valid with that data. Corrupting data bit 0 instead gives crc_err.
- Token stalled after 5 addr bits with rx_valid low for 255 cycles -> timeout_err, HUNT. At 254 stall cycles then resume -> normal pkt_valid.
- rst asserted mid-DAT, then a complete handshake packet -> no output from the aborted packet; handshake decoded correctly. With USB_RX_ADDR_FILTER_EN, a token to addr 7'h01 -> no pkt_valid.
